// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared helpers, polarity constants and standard VESA mode sets
package vga_timing_pkg;
   localparam bit POL_NEG = 1'b0;
   localparam bit POL_POS = 1'b1;

   typedef struct packed {
      int h_active;
      int h_front;
      int h_sync;
      int h_back;
      int v_active;
      int v_front;
      int v_sync;
      int v_back;
      bit hs_pol;
      bit vs_pol;
   } vga_mode_t;

   localparam vga_mode_t MODE_640X480 = '{
      h_active: 640, h_front: 16, h_sync: 96, h_back: 48,
      v_active: 480, v_front: 10, v_sync: 2, v_back: 33,
      hs_pol: POL_NEG, vs_pol: POL_NEG};

   localparam vga_mode_t MODE_800X600 = '{
      h_active: 800, h_front: 40, h_sync: 128, h_back: 88,
      v_active: 600, v_front: 1, v_sync: 4, v_back: 23,
      hs_pol: POL_POS, vs_pol: POL_POS};

   localparam vga_mode_t MODE_1024X768 = '{
      h_active: 1024, h_front: 24, h_sync: 136, h_back: 160,
      v_active: 768, v_front: 3, v_sync: 6, v_back: 29,
      hs_pol: POL_NEG, vs_pol: POL_NEG};

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: ce-gated shift register with per-bit reset values; DEPTH=0 is a wire
module vga_delay_line #(
   parameter int               WIDTH   = 5,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_ce,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   if (DEPTH == 0) begin : g_pass
      assign o_q = i_d;
   end else begin : g_sr
      logic [WIDTH-1:0] r_sr [DEPTH];
      always_ff @(posedge i_clk) begin
         if (!i_reset_n) begin
            for (int k = 0; k < DEPTH; k++) r_sr[k] <= RST_VAL;
         end else if (i_ce) begin
            r_sr[0] <= i_d;
            for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
         end
      end
      assign o_q = r_sr[DEPTH-1];
   end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with coordinates issued LOOKAHEAD
// pixel periods ahead of sync/active so a pipelined pixel source lines up at the pins
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE       = 640,
   parameter int H_FRONT_PORCH  = 16,
   parameter int H_SYNC         = 96,
   parameter int H_BACK_PORCH   = 48,
   parameter int V_ACTIVE       = 480,
   parameter int V_FRONT_PORCH  = 10,
   parameter int V_SYNC         = 2,
   parameter int V_BACK_PORCH   = 33,
   parameter bit HS_ACTIVE_HIGH = 1'b0,
   parameter bit VS_ACTIVE_HIGH = 1'b0,
   parameter int LOOKAHEAD      = 2,
   localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH,
   localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH,
   localparam int H_W     = clog2(H_TOTAL),
   localparam int V_W     = clog2(V_TOTAL)
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   input  logic           i_ce,
   output logic           o_req,
   output logic [H_W-1:0] o_px,
   output logic [V_W-1:0] o_py,
   output logic           o_hs,
   output logic           o_vs,
   output logic           o_active,
   output logic           o_line_start,
   output logic           o_frame_start
);
   if (H_FRONT_PORCH < 1 || H_SYNC < 1 || H_BACK_PORCH < 1 || V_FRONT_PORCH < 1 ||
       V_SYNC < 1 || V_BACK_PORCH < 1 || LOOKAHEAD < 0 || LOOKAHEAD > 15) begin : g_bad_cfg
      $fatal(1, "vga_timing_gen: illegal porch/sync/lookahead parameters");
   end

   localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0] H_SB   = H_W'(H_ACTIVE + H_FRONT_PORCH);
   localparam logic [H_W-1:0] H_SE   = H_W'(H_ACTIVE + H_FRONT_PORCH + H_SYNC);
   localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0] V_SB   = V_W'(V_ACTIVE + V_FRONT_PORCH);
   localparam logic [V_W-1:0] V_SE   = V_W'(V_ACTIVE + V_FRONT_PORCH + V_SYNC);
   localparam logic [4:0]     DISP_RST = {~HS_ACTIVE_HIGH, ~VS_ACTIVE_HIGH, 3'b000};

   logic [H_W-1:0] r_h;
   logic [V_W-1:0] r_v;
   logic           r_req;
   logic [H_W-1:0] r_px;
   logic [V_W-1:0] r_py;
   logic [4:0]     r_disp;
   logic [4:0]     w_disp;
   logic [4:0]     w_dly;
   logic           w_h_last;
   logic           w_v_last;
   logic           w_req;
   logic           w_hs_on;
   logic           w_vs_on;

   assign w_h_last = r_h == H_LAST;
   assign w_v_last = r_v == V_LAST;
   assign w_req    = (r_h < H_ACT) && (r_v < V_ACT);
   assign w_hs_on  = (r_h >= H_SB) && (r_h < H_SE);
   assign w_vs_on  = (r_v >= V_SB) && (r_v < V_SE);
   // Display bits are carried at pin polarity so the delay line resets to idle levels
   assign w_disp = {w_hs_on ~^ HS_ACTIVE_HIGH, w_vs_on ~^ VS_ACTIVE_HIGH, w_req,
                    r_h == '0, (r_h == '0) && (r_v == '0)};

   vga_delay_line #(.WIDTH(5), .DEPTH(LOOKAHEAD), .RST_VAL(DISP_RST)) u_dly (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_ce      (i_ce),
      .i_d       (w_disp),
      .o_q       (w_dly)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_h    <= '0;
         r_v    <= '0;
         r_req  <= 1'b0;
         r_px   <= '0;
         r_py   <= '0;
         r_disp <= DISP_RST;
      end else if (i_ce) begin
         r_h    <= w_h_last ? '0 : r_h + 1'b1;
         if (w_h_last) r_v <= w_v_last ? '0 : r_v + 1'b1;
         r_req  <= w_req;
         r_px   <= w_req ? r_h : '0;
         r_py   <= w_req ? r_v : '0;
         r_disp <= w_dly;
      end
   end

   assign o_req = r_req;
   assign o_px  = r_px;
   assign o_py  = r_py;
   assign {o_hs, o_vs, o_active, o_line_start, o_frame_start} = r_disp;
endmodule
